// File: rtl/lut_fsm_engine.sv
// Table-driven Moore FSM: a serially loaded next-state/output table drives a small run-time engine.
// Optional per-state timer with capture/compare is built only when LUT_FSM_TIMER_EN is defined.
module lut_fsm_engine #(
    parameter int IN_W    = 5,
    parameter int OUT_W   = 5,
    parameter int NSTATES = 8,
    parameter int TMR_W   = 20,
    localparam int SW       = $clog2(NSTATES),
    localparam int ENTRY_W  = IN_W + 2*SW + OUT_W + 2,
    localparam int TBL_BITS = NSTATES*ENTRY_W
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             cfg_clear,
    input  logic             cfg_en,
    input  logic             cfg_bit,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic [SW-1:0]    state,
    output logic             ready,
    output logic             tmr_eq
);

    // state   | meaning
    // LOAD    | shifting table bits in; engine parked at state 0, outputs 0
    // RUN     | table complete; engine steps every cycle, cfg_en ignored
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int CW = $clog2(TBL_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(TBL_BITS-1);
    localparam logic [SW:0]   NST_LIM  = (SW+1)'(NSTATES);

    logic [0:0]          ctrl;
    logic [CW-1:0]       bit_cnt;
    logic [TBL_BITS-1:0] tbl;
    logic [ENTRY_W-1:0]  cur;
    logic                run;
    logic                hit;
    logic [SW-1:0]       nxt_raw;
    logic [SW-1:0]       nxt;
    logic                tmr_run;
    logic                tmr_cap;

    assign run = (ctrl == ST_RUN);

    // Entry 0 is shifted in first, so it ends up in the top ENTRY_W bits.
    always_comb begin
        cur = '0;
        for (int k = 0; k < NSTATES; k++) begin
            if (state == SW'(k)) begin
                cur = tbl[TBL_BITS-1-k*ENTRY_W -: ENTRY_W];
            end
        end
    end

    assign hit     = (in == cur[IN_W-1:0]);
    assign nxt_raw = hit ? cur[IN_W +: SW] : cur[IN_W+SW +: SW];
    assign tmr_run = cur[ENTRY_W-2];
    assign tmr_cap = cur[ENTRY_W-1];

    generate
        if ((1 << SW) == NSTATES) begin : g_full
            assign nxt = nxt_raw;
        end else begin : g_wrap
            assign nxt = ({1'b0, nxt_raw} < NST_LIM) ? nxt_raw : '0;
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ctrl    <= ST_LOAD;
            bit_cnt <= '0;
            tbl     <= '0;
        end else if (cfg_clear) begin
            ctrl    <= ST_LOAD;
            bit_cnt <= '0;
            tbl     <= '0;
        end else if (ctrl == ST_LOAD && cfg_en) begin
            tbl <= {tbl[TBL_BITS-2:0], cfg_bit};
            if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                ctrl    <= ST_RUN;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= '0;
        end else if (cfg_clear) begin
            state <= '0;
        end else if (run) begin
            state <= nxt;
        end
    end

    assign out   = run ? cur[IN_W+2*SW +: OUT_W] : '0;
    assign ready = run;

`ifdef LUT_FSM_TIMER_EN
    logic [TMR_W-1:0] tmr_cnt;
    logic [TMR_W-1:0] tmr_capv;
    logic             clr_pend;

    // The clear lands one edge after the capture edge, so the captured value
    // stays visible against the count for one cycle.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tmr_cnt  <= '0;
            tmr_capv <= '0;
            clr_pend <= 1'b0;
        end else if (cfg_clear || !run) begin
            tmr_cnt  <= '0;
            tmr_capv <= '0;
            clr_pend <= 1'b0;
        end else begin
            if (clr_pend) begin
                tmr_cnt <= '0;
            end else if (tmr_run && tmr_cnt != '1) begin
                tmr_cnt <= tmr_cnt + TMR_W'(1);
            end
            if (tmr_cap) begin
                tmr_capv <= tmr_cnt;
            end
            clr_pend <= tmr_cap;
        end
    end

    assign tmr_eq = run && (tmr_cnt == tmr_capv);
`else
    logic unused_tmr_bits;
    assign unused_tmr_bits = tmr_run ^ tmr_cap;
    assign tmr_eq = 1'b0;
`endif

endmodule
